// File: rtl/branch_predictor_if.sv
// Bus between the pipeline (IF fetch PC, EX resolved branch) and the
// branch history table. The pipeline drives the master side and the
// predictor sits on the slave side.
interface branch_predictor_if #(
  parameter int CNT_WIDTH = 16
);
  logic [31:0]          if_pc_i;
  logic                 pred_taken_o;
  logic                 upd_valid_i;
  logic [31:0]          upd_pc_i;
  logic                 upd_taken_i;
  logic                 upd_pred_i;
  logic                 mispredict_o;
  logic [CNT_WIDTH-1:0] br_count_o;
  logic [CNT_WIDTH-1:0] miss_count_o;

  modport master (
    output if_pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_pred_i,
    input  pred_taken_o, mispredict_o, br_count_o, miss_count_o
  );

  modport slave (
    input  if_pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_pred_i,
    output pred_taken_o, mispredict_o, br_count_o, miss_count_o
  );
endinterface

// File: rtl/branch_predictor.sv
// 2-bit saturating-counter branch history table with misprediction
// flag and saturating branch / miss statistics counters.
// Entry encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
module branch_predictor #(
  parameter int IDX_BITS  = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  branch_predictor_if.slave  bus
);
  localparam int ENTRIES = 1 << IDX_BITS;

  logic [1:0]           bht_q [ENTRIES];
  logic [1:0]           bht_d [ENTRIES];
  logic [CNT_WIDTH-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;

  logic [IDX_BITS-1:0]  rd_idx_s;
  logic [IDX_BITS-1:0]  upd_idx_s;
  logic                 mispredict_s;

  // PC bits outside the index field are deliberately ignored (aliasing allowed)
  logic unused_pc_bits_s;
  assign unused_pc_bits_s = ^{bus.if_pc_i[31:IDX_BITS+2], bus.if_pc_i[1:0],
                              bus.upd_pc_i[31:IDX_BITS+2], bus.upd_pc_i[1:0]};

  assign rd_idx_s  = bus.if_pc_i[IDX_BITS+1:2];
  assign upd_idx_s = bus.upd_pc_i[IDX_BITS+1:2];

  // Gating with upd_valid_i keeps the flag at 0 even if the update fields are X
  assign mispredict_s = bus.upd_valid_i & (bus.upd_taken_i ^ bus.upd_pred_i);

  // Prediction reads the pre-update table: no same-cycle bypass
  assign bus.pred_taken_o = bht_q[rd_idx_s][1];
  assign bus.mispredict_o = mispredict_s;
  assign bus.br_count_o   = br_cnt_q;
  assign bus.miss_count_o = miss_cnt_q;

  // Next-state for the indexed counter and the statistics on a valid update
  always_comb begin
    bht_d      = bht_q;
    br_cnt_d   = br_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (bus.upd_valid_i) begin
      if (bus.upd_taken_i) begin
        if (bht_q[upd_idx_s] != 2'b11) begin
          bht_d[upd_idx_s] = bht_q[upd_idx_s] + 2'b01;
        end else begin
          bht_d[upd_idx_s] = 2'b11;
        end
      end else begin
        if (bht_q[upd_idx_s] != 2'b00) begin
          bht_d[upd_idx_s] = bht_q[upd_idx_s] - 2'b01;
        end else begin
          bht_d[upd_idx_s] = 2'b00;
        end
      end
      if (br_cnt_q != {CNT_WIDTH{1'b1}}) begin
        br_cnt_d = br_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        br_cnt_d = br_cnt_q;
      end
      if (mispredict_s && (miss_cnt_q != {CNT_WIDTH{1'b1}})) begin
        miss_cnt_d = miss_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        miss_cnt_d = miss_cnt_q;
      end
    end else begin
      br_cnt_d   = br_cnt_q;
      miss_cnt_d = miss_cnt_q;
    end
  end

  // Table and counter flops; synchronous active-low reset wins over updates
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        bht_q[i] <= 2'b01;
      end
      br_cnt_q   <= {CNT_WIDTH{1'b0}};
      miss_cnt_q <= {CNT_WIDTH{1'b0}};
    end else begin
      bht_q      <= bht_d;
      br_cnt_q   <= br_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed vector table,
// hand-written corner sequences, and random traffic against a model.
module tb_branch_predictor;
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;

  branch_predictor_if #(.CNT_WIDTH(16)) bus  ();
  branch_predictor_if #(.CNT_WIDTH(4))  bus4 ();

  branch_predictor #(.IDX_BITS(4), .CNT_WIDTH(16)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  branch_predictor #(.IDX_BITS(4), .CNT_WIDTH(4)) dut4 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus4)
  );

  // 10 ns clock
  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // Reference model: plain integer counters per table entry
  int m_tbl [16];
  int m_br;
  int m_miss;

  typedef struct {
    logic [31:0] pc;
    logic        t;
    logic        p;
    logic        mis;
    logic        pred_after;
    int          br;
    int          miss;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_idx(input logic [31:0] pc);
    return int'(pc[5:2]);
  endfunction

  function automatic logic m_pred(input logic [31:0] pc);
    return (m_tbl[m_idx(pc)] >= 2);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) m_tbl[i] = 1;
    m_br = 0;
    m_miss = 0;
  endtask

  task automatic m_update(input logic v, input logic [31:0] pc, input logic t, input logic p);
    int i;
    if (v) begin
      i = m_idx(pc);
      m_tbl[i] = t ? ((m_tbl[i] + 1 > 3) ? 3 : m_tbl[i] + 1)
                   : ((m_tbl[i] - 1 < 0) ? 0 : m_tbl[i] - 1);
      m_br = (m_br + 1 > 65535) ? 65535 : m_br + 1;
      if (t != p) m_miss = (m_miss + 1 > 65535) ? 65535 : m_miss + 1;
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_upd(input logic [31:0] pc, input logic t, input logic p);
    bus.upd_valid_i = 1'b1;
    bus.upd_pc_i    = pc;
    bus.upd_taken_i = t;
    bus.upd_pred_i  = p;
  endtask

  task automatic sweep_reset_state(input string tag);
    for (int k = 0; k < 16; k++) begin
      bus.if_pc_i = 32'(k * 4);
      #1;
      chk({tag, "_pred"}, {31'b0, bus.pred_taken_o}, 32'h0);
    end
    chk({tag, "_br"},   {16'b0, bus.br_count_o},   32'h0);
    chk({tag, "_miss"}, {16'b0, bus.miss_count_o}, 32'h0);
  endtask

  // Main stimulus sequence
  initial begin
    logic        rv, rt, rp;
    logic [31:0] rpc, rif;

    vecs[0]  = '{32'h10, 1'b1, 1'b0, 1'b1, 1'b1,  1, 1};
    vecs[1]  = '{32'h10, 1'b1, 1'b0, 1'b1, 1'b1,  2, 2};
    vecs[2]  = '{32'h10, 1'b1, 1'b1, 1'b0, 1'b1,  3, 2};
    vecs[3]  = '{32'h24, 1'b1, 1'b0, 1'b1, 1'b1,  4, 3};
    vecs[4]  = '{32'h24, 1'b1, 1'b1, 1'b0, 1'b1,  5, 3};
    vecs[5]  = '{32'h24, 1'b0, 1'b1, 1'b1, 1'b1,  6, 4};
    vecs[6]  = '{32'h24, 1'b0, 1'b1, 1'b1, 1'b0,  7, 5};
    vecs[7]  = '{32'h24, 1'b0, 1'b0, 1'b0, 1'b0,  8, 5};
    vecs[8]  = '{32'h24, 1'b0, 1'b0, 1'b0, 1'b0,  9, 5};
    vecs[9]  = '{32'h24, 1'b0, 1'b0, 1'b0, 1'b0, 10, 5};
    vecs[10] = '{32'h24, 1'b0, 1'b0, 1'b0, 1'b0, 11, 5};
    vecs[11] = '{32'h24, 1'b1, 1'b0, 1'b1, 1'b0, 12, 6};

    bus.if_pc_i = 32'h0;  bus.upd_valid_i = 1'b0;
    bus.upd_pc_i = 32'h0; bus.upd_taken_i = 1'b0; bus.upd_pred_i = 1'b0;
    bus4.if_pc_i = 32'h0; bus4.upd_valid_i = 1'b0;
    bus4.upd_pc_i = 32'h0; bus4.upd_taken_i = 1'b0; bus4.upd_pred_i = 1'b0;

    // Reset for two cycles, then check every entry predicts not-taken
    rst_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    m_reset();
    sweep_reset_state("reset");

    // Training, saturation and hysteresis vectors
    for (int r = 0; r < 12; r++) begin
      drive_upd(vecs[r].pc, vecs[r].t, vecs[r].p);
      bus.if_pc_i = vecs[r].pc;
      #1;
      chk($sformatf("vec%0d_mispredict", r), {31'b0, bus.mispredict_o}, {31'b0, vecs[r].mis});
      m_update(1'b1, vecs[r].pc, vecs[r].t, vecs[r].p);
      tick();
      bus.upd_valid_i = 1'b0;
      #1;
      chk($sformatf("vec%0d_pred", r), {31'b0, bus.pred_taken_o}, {31'b0, vecs[r].pred_after});
      chk($sformatf("vec%0d_br", r),   {16'b0, bus.br_count_o},   32'(vecs[r].br));
      chk($sformatf("vec%0d_miss", r), {16'b0, bus.miss_count_o}, 32'(vecs[r].miss));
    end

    // Aliased same-cycle read/write: no bypass
    drive_upd(32'h04, 1'b1, 1'b0);
    bus.if_pc_i = 32'h44;
    #1;
    chk("alias_same_cycle_pred", {31'b0, bus.pred_taken_o}, 32'h0);
    chk("alias_mispredict",      {31'b0, bus.mispredict_o}, 32'h1);
    m_update(1'b1, 32'h04, 1'b1, 1'b0);
    tick();
    bus.upd_valid_i = 1'b0;
    #1;
    chk("alias_next_cycle_pred", {31'b0, bus.pred_taken_o}, 32'h1);
    bus.if_pc_i = 32'h04;
    #1;
    chk("alias_pc04_pred", {31'b0, bus.pred_taken_o}, 32'h1);
    bus.if_pc_i = 32'h08;
    #1;
    chk("neighbour_pc08_pred", {31'b0, bus.pred_taken_o}, 32'h0);

    // Invalid updates with garbage fields must change nothing
    for (int k = 0; k < 4; k++) begin
      bus.upd_valid_i = 1'b0;
      bus.upd_pc_i    = 32'hx;
      bus.upd_taken_i = k[0];
      bus.upd_pred_i  = ~k[0];
      #1;
      chk("invalid_mispredict", {31'b0, bus.mispredict_o}, 32'h0);
      tick();
    end
    chk("invalid_br",   {16'b0, bus.br_count_o},   32'd13);
    chk("invalid_miss", {16'b0, bus.miss_count_o}, 32'd7);
    bus.if_pc_i = 32'h10;
    #1;
    chk("invalid_pc10_pred", {31'b0, bus.pred_taken_o}, 32'h1);

    // Reset coinciding with a valid mispredicted update: reset wins
    drive_upd(32'h10, 1'b0, 1'b1);
    rst_i = 1'b0;
    #1;
    tick();
    rst_i = 1'b1;
    bus.upd_valid_i = 1'b0;
    m_reset();
    sweep_reset_state("midreset");
    // Entry must be exactly 01: one taken update flips it to predict taken
    drive_upd(32'h10, 1'b1, 1'b0);
    m_update(1'b1, 32'h10, 1'b1, 1'b0);
    tick();
    bus.upd_valid_i = 1'b0;
    bus.if_pc_i = 32'h10;
    #1;
    chk("midreset_weak_nt_pred", {31'b0, bus.pred_taken_o}, 32'h1);
    chk("midreset_br",   {16'b0, bus.br_count_o},   32'd1);
    chk("midreset_miss", {16'b0, bus.miss_count_o}, 32'd1);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      rv  = ($urandom_range(0, 3) != 0);
      rpc = $urandom;
      rt  = $urandom_range(0, 1) == 1;
      rp  = $urandom_range(0, 1) == 1;
      rif = $urandom;
      bus.upd_valid_i = rv;
      bus.upd_pc_i    = rpc;
      bus.upd_taken_i = rt;
      bus.upd_pred_i  = rp;
      bus.if_pc_i     = rif;
      #1;
      chk("rand_pred",       {31'b0, bus.pred_taken_o}, {31'b0, m_pred(rif)});
      chk("rand_mispredict", {31'b0, bus.mispredict_o}, {31'b0, rv & (rt ^ rp)});
      m_update(rv, rpc, rt, rp);
      tick();
      chk("rand_br",   {16'b0, bus.br_count_o},   32'(m_br));
      chk("rand_miss", {16'b0, bus.miss_count_o}, 32'(m_miss));
    end
    bus.upd_valid_i = 1'b0;

    // Statistics saturation on the 4-bit instance
    chk("sat4_start_br", {28'b0, bus4.br_count_o}, 32'h0);
    for (int n = 1; n <= 20; n++) begin
      bus4.upd_valid_i = 1'b1;
      bus4.upd_pc_i    = $urandom;
      bus4.upd_taken_i = 1'b1;
      bus4.upd_pred_i  = 1'b0;
      #1;
      tick();
      bus4.upd_valid_i = 1'b0;
      #1;
      chk($sformatf("sat4_br_%0d", n),   {28'b0, bus4.br_count_o},   32'((n > 15) ? 15 : n));
      chk($sformatf("sat4_miss_%0d", n), {28'b0, bus4.miss_count_o}, 32'((n > 15) ? 15 : n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
